// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter funnelling NUM_REQ burst writers into one FIFO write port.
// A grant lasts until req_last or MAX_BURST words, then one IDLE cycle re-arbitrates.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_SIZE = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                         wclk,
  input  logic                         wrst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DATA_SIZE-1:0] req_data,
  input  logic [NUM_REQ-1:0]           req_last,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic                         wfull,
  output logic                         winc,
  output logic [DATA_SIZE-1:0]         wdata,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         busy
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t        state, state_d;
  logic [GW-1:0] last_grant, last_grant_d;
  logic [GW-1:0] grant_d;
  logic [CW-1:0] beat_cnt, beat_d;
  logic [CW:0]   beat_inc;

  logic [GW-1:0] pick;
  logic [GW-1:0] cand;
  logic          found;

  // Scan upward from the requester after the last one served, wrapping.
  always_comb begin
    pick  = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = GW'((int'(last_grant) + k) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign beat_inc = {1'b0, beat_cnt} + 1'b1;
  assign wdata    = req_data[grant_id*DATA_SIZE +: DATA_SIZE];

  always_comb begin
    state_d      = state;
    grant_d      = grant_id;
    beat_d       = beat_cnt;
    last_grant_d = last_grant;
    winc         = 1'b0;
    busy         = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          grant_d = pick;
          beat_d  = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        busy = 1'b1;
        winc = req_valid[grant_id] & ~wfull;
        if (winc) begin
          beat_d = beat_inc[CW-1:0];
          // Burst end and burst limit share one release path.
          if (req_last[grant_id] || (beat_inc == (CW+1)'(MAX_BURST))) begin
            last_grant_d = grant_id;
            state_d      = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready           = '0;
    req_ready[grant_id] = winc;
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state      <= IDLE;
      beat_cnt   <= '0;
      grant_id   <= '0;
      last_grant <= GW'(NUM_REQ - 1);
    end else begin
      state      <= state_d;
      beat_cnt   <= beat_d;
      grant_id   <= grant_d;
      last_grant <= last_grant_d;
    end
  end

endmodule
